fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 9 +
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl_target.sv | 37 +++
 rtl/fetch_ctrl.sv | 75 +++++++
 tb/tb_fetch_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding, branch opcodes and default addresses for fetch_ctrl.
package fetch_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FLUSH} state_t;
  localparam logic [2:0] BR_BRANCH = 3'b001;
  localparam logic [2:0] BR_JUMP = 3'b010;
  localparam logic [2:0] BR_JR = 3'b011;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_4180;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory, decode and redirect signals of the fetch stage.
interface fetch_ctrl_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic id_stall;
  logic br_valid;
  logic [2:0] br_op;
  logic [25:0] br_imm;
  logic [31:0] br_ra;
  logic [31:0] br_pc;
  logic exc_req;
  logic eret_req;
  logic [31:0] epc;
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input imem_ack, imem_rdata, id_stall, br_valid, br_op, br_imm, br_ra, br_pc, exc_req, eret_req, epc
  );
  modport slave (
    input imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, id_stall, br_valid, br_op, br_imm, br_ra, br_pc, exc_req, eret_req, epc
  );
endinterface

// File: rtl/fetch_ctrl_target.sv
// fetch_target: combinational next-pc selection; exception/eret inputs honoured only with FETCH_EXC_EN.
module fetch_target import fetch_ctrl_pkg::*; #(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic        br_valid,
  input  logic [2:0]  br_op,
  input  logic [25:0] br_imm,
  input  logic [31:0] br_ra,
  input  logic [31:0] br_pc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq
);
  logic br_hit;
  logic [31:0] br_tgt;
  always_comb begin
    seq = pc + 32'd4;
    br_hit = br_valid && (br_op == BR_BRANCH || br_op == BR_JUMP || br_op == BR_JR);
    br_tgt = br_op == BR_BRANCH ? br_pc + {{14{br_imm[15]}}, br_imm[15:0], 2'b00} :
             br_op == BR_JUMP ? {br_pc[31:28], br_imm, 2'b00} : br_ra;
`ifdef FETCH_EXC_EN
    redirect = exc_req || eret_req || br_hit;
    target = exc_req ? EXC_VEC : eret_req ? epc : br_hit ? br_tgt : seq;
`else
    redirect = br_hit;
    target = br_hit ? br_tgt : seq;
`endif
  end
`ifndef FETCH_EXC_EN
  logic unused;
  assign unused = ^{exc_req, eret_req, epc};
`endif
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch FSM with branch/jump redirect and flush of in-flight fetches.
// Optional exception entry/return is enabled by defining FETCH_EXC_EN.
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input logic clk,
  input logic reset,
  fetch_ctrl_if.master bus
);
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, ipc, ipc_nx, ins, ins_nx, target, seq;
  logic vld, vld_nx, redirect;
  fetch_target #(.EXC_VEC(EXC_VEC)) u_target (
    .pc(pc), .br_valid(bus.br_valid), .br_op(bus.br_op), .br_imm(bus.br_imm),
    .br_ra(bus.br_ra), .br_pc(bus.br_pc), .exc_req(bus.exc_req), .eret_req(bus.eret_req),
    .epc(bus.epc), .redirect(redirect), .target(target), .seq(seq)
  );
  assign bus.imem_req = state == REQ || state == WAIT;
  assign bus.imem_addr = {pc[31:2], 2'b00};
  assign bus.if_valid = vld;
  assign bus.if_pc = ipc;
  assign bus.if_instr = ins;
  // A presented instruction is consumed on any cycle decode is not stalling.
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    vld_nx = vld && bus.id_stall;
    ipc_nx = ipc;
    ins_nx = ins;
    case (state)
      IDLE: state_nx = REQ;
      REQ, WAIT: begin
        if (redirect) begin
          pc_nx = target;
          vld_nx = 1'b0;
          state_nx = bus.imem_ack ? REQ : FLUSH;
        end else if (bus.imem_ack) begin
          pc_nx = seq;
          vld_nx = 1'b1;
          ipc_nx = bus.imem_addr;
          ins_nx = bus.imem_rdata;
          state_nx = bus.id_stall ? HOLD : REQ;
        end else state_nx = WAIT;
      end
      HOLD: begin
        if (redirect) begin
          pc_nx = target;
          vld_nx = 1'b0;
          state_nx = REQ;
        end else if (!bus.id_stall) state_nx = REQ;
      end
      FLUSH: begin
        if (redirect) pc_nx = target;
        if (bus.imem_ack) state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      vld <= 1'b0;
      ipc <= '0;
      ins <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      vld <= vld_nx;
      ipc <= ipc_nx;
      ins <= ins_nx;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios with a cycle model of fetch behaviour compared every negedge.
module tb_fetch_ctrl;
  localparam logic [31:0] K = 32'hDEAD_0000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0, passed = 0;
  fetch_ctrl_if bus();
  fetch_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = bus.imem_addr ^ K;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
  endtask

  // model: mode 0 idle, 1 fetching, 2 holding for decode, 3 waiting to drop a stale ack
  int mode;
  logic [31:0] m_pc, m_ipc, m_ins;
  bit m_v;

  function automatic void want_redirect(output bit hit, output logic [31:0] t);
    hit = 1'b0;
    t = '0;
`ifdef FETCH_EXC_EN
    if (bus.exc_req) begin hit = 1'b1; t = 32'h0000_4180; return; end
    if (bus.eret_req) begin hit = 1'b1; t = bus.epc; return; end
`endif
    if (!bus.br_valid) return;
    if (bus.br_op == 3'd1) begin hit = 1'b1; t = bus.br_pc + 32'(int'($signed(bus.br_imm[15:0])) * 4); end
    if (bus.br_op == 3'd2) begin hit = 1'b1; t = (bus.br_pc & 32'hF000_0000) | (32'(bus.br_imm) << 2); end
    if (bus.br_op == 3'd3) begin hit = 1'b1; t = bus.br_ra; end
  endfunction

  always @(posedge clk or posedge reset) begin
    bit hit;
    logic [31:0] t;
    if (reset) begin
      mode = 0; m_pc = 32'h3000; m_v = 0; m_ipc = 0; m_ins = 0;
    end else begin
      want_redirect(hit, t);
      if (mode == 0) mode = 1;
      else if (hit && mode != 3) begin
        m_pc = t; m_v = 0;
        mode = (mode == 1 && !bus.imem_ack) ? 3 : 1;
      end else if (mode == 3) begin
        if (hit) m_pc = t;
        if (bus.imem_ack) mode = 1;
      end else if (mode == 1 && bus.imem_ack) begin
        m_ipc = m_pc; m_ins = m_pc ^ K; m_v = 1; m_pc = m_pc + 4;
        mode = bus.id_stall ? 2 : 1;
      end else begin
        m_v = m_v && bus.id_stall;
        if (mode == 2 && !bus.id_stall) mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_req", 32'(bus.imem_req), 32'(mode == 1));
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", 32'(bus.if_valid), 32'(m_v));
    if (m_v) begin
      chk("if_pc", bus.if_pc, m_ipc);
      chk("if_instr", bus.if_instr, m_ins);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut();
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h3000);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic br(input logic [2:0] op, input logic [31:0] pcv, input logic [25:0] imm, input logic [31:0] ra);
    bus.br_valid = 1'b1; bus.br_op = op; bus.br_pc = pcv; bus.br_imm = imm; bus.br_ra = ra;
  endtask

  initial begin
    bus.imem_ack = 0; bus.id_stall = 0; bus.br_valid = 0; bus.br_op = 0; bus.br_imm = 0;
    bus.br_ra = 0; bus.br_pc = 0; bus.exc_req = 0; bus.eret_req = 0; bus.epc = 0;
    #2;
    bus.imem_ack = 1;
    rst_dut();
    chk("a_first", bus.imem_addr, 32'h3000);
    chk("a_pc0", 32'(dut.bus.if_pc), 32'h0);
    tick();
    chk("a_second", bus.imem_addr, 32'h3004);
    chk("a_lag", bus.if_pc, 32'h3000);
    tick();
    chk("a_third", bus.imem_addr, 32'h3008);
    chk("a_instr", bus.if_instr, 32'h3004 ^ K);
    rst_dut();
    tick();
    bus.id_stall = 1;
    tick();
    chk("b_hold_req", 32'(bus.imem_req), 32'd0);
    chk("b_hold_pc", bus.if_pc, 32'h3004);
    tick();
    chk("b_hold_pc2", bus.if_pc, 32'h3004);
    chk("b_hold_ins", bus.if_instr, 32'h3004 ^ K);
    bus.id_stall = 0;
    tick();
    chk("b_resume", bus.imem_addr, 32'h3008);
    bus.imem_ack = 0;
    rst_dut();
    for (int i = 0; i < 3; i++) begin
      chk("c_held", bus.imem_addr, 32'h3000);
      chk("c_novalid", 32'(bus.if_valid), 32'd0);
      tick();
    end
    chk("c_held4", bus.imem_addr, 32'h3000);
    bus.imem_ack = 1;
    tick();
    chk("c_valid", 32'(bus.if_valid), 32'd1);
    chk("c_pc", bus.if_pc, 32'h3000);
    rst_dut();
    tick();
    br(3'b001, 32'h3010, 26'h000FFFC, 32'h0);
    tick();
    chk("d_addr", bus.imem_addr, 32'h3000);
    chk("d_flush", 32'(bus.if_valid), 32'd0);
    bus.br_valid = 0;
    tick();
    chk("d_refetch", bus.if_pc, 32'h3000);
    bus.imem_ack = 0;
    rst_dut();
    tick();
    br(3'b011, 32'h0, 26'h0, 32'h4000);
    tick();
    chk("e_flush_req", 32'(bus.imem_req), 32'd0);
    bus.br_valid = 0;
    tick();
    bus.imem_ack = 1;
    tick();
    chk("e_addr", bus.imem_addr, 32'h4000);
    chk("e_stale", 32'(bus.if_valid), 32'd0);
    tick();
    chk("e_pc", bus.if_pc, 32'h4000);
    br(3'b010, 32'hA000_1234, 26'h0000400, 32'h0);
    tick();
    chk("f_jump", bus.imem_addr, 32'hA000_1000);
    bus.br_op = 3'b100;
    tick();
    chk("f_badop", bus.imem_addr, 32'hA000_1004);
    br(3'b011, 32'h0, 26'h0, 32'hFFFF_FFFC);
    tick();
    chk("g_top", bus.imem_addr, 32'hFFFF_FFFC);
    bus.br_valid = 0;
    tick();
    chk("g_wrap", bus.imem_addr, 32'h0);
    bus.imem_ack = 0;
    rst_dut();
    tick();
    reset = 1;
    #1;
    chk("h_abandon", 32'(bus.imem_req), 32'd0);
    tick();
    bus.imem_ack = 1;
    reset = 0;
    tick();
    chk("h_stale", 32'(bus.if_valid), 32'd0);
    rst_dut();
    bus.exc_req = 1;
    br(3'b011, 32'h0, 26'h0, 32'h4000);
    tick();
`ifdef FETCH_EXC_EN
    chk("i_exc", bus.imem_addr, 32'h4180);
`else
    chk("i_exc", bus.imem_addr, 32'h4000);
`endif
    bus.exc_req = 0; bus.br_valid = 0; bus.eret_req = 1; bus.epc = 32'h3020;
    tick();
`ifdef FETCH_EXC_EN
    chk("i_eret", bus.imem_addr, 32'h3020);
`else
    chk("i_eret", bus.imem_addr, 32'h4004);
`endif
    bus.eret_req = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
